// File: rtl/fl_fix_conv_pipe.sv
// Three-stage streaming converter between IEEE-754 single precision and signed fixed point.
// Direction is chosen per transaction; a single global enable stalls every stage together.
module fl_fix_conv_pipe #(
  parameter int unsigned INT_BITS  = 2,
  parameter int unsigned FRAC_BITS = 20,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_mode,
  output logic             out_ovf,
  output logic             out_nan
);

  localparam int unsigned W  = INT_BITS + FRAC_BITS;
  localparam int unsigned MW = W + 1;

  // Smallest biased exponent whose magnitude no longer fits the integer field.
  localparam logic [7:0]   OVF_EXP  = 8'(126 + INT_BITS);
  // Right-shift applied to {1.m, 32'b0} so the result lands on the fixed-point grid.
  localparam logic [8:0]   RSH_BASE = 9'(182 - FRAC_BITS);
  localparam logic [W-1:0] POS_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MIN  = {1'b1, {(W-1){1'b0}}};

  function automatic logic [31:0] sext(input logic [W-1:0] v);
    return 32'(signed'(v));
  endfunction

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- Stage 1: unpack, classify, abs, leading-one detect ----------------
  logic [7:0]    f_exp;
  logic [22:0]   f_man;
  logic          f_nan, f_big, f_min;
  logic [8:0]    f_rsh;
  logic [W-1:0]  x_val;
  logic [MW-1:0] x_ext, x_mag;
  logic [5:0]    lod;

  assign f_exp = in_data[30:23];
  assign f_man = in_data[22:0];
  assign f_nan = (f_exp == 8'hFF) && (f_man != '0);
  assign f_big = f_exp >= OVF_EXP;
  assign f_min = in_data[31] && (f_exp == OVF_EXP) && (f_man == '0);
  assign f_rsh = RSH_BASE - {1'b0, f_exp};

  // One extra bit keeps the magnitude of the most negative input exact.
  assign x_val = in_data[W-1:0];
  assign x_ext = {x_val[W-1], x_val};
  assign x_mag = x_val[W-1] ? -x_ext : x_ext;

  always_comb begin
    lod = '0;
    for (int i = 0; i < MW; i++) begin
      if (x_mag[i]) lod = 6'(i);
    end
  end

  logic             v1_q, mode1_q, sign1_q, zero1_q, nan1_q, sat1_q, min1_q;
  logic [TAG_W-1:0] tag1_q;
  logic [23:0]      sig1_q;
  logic [8:0]       rsh1_q;
  logic [MW-1:0]    mag1_q;
  logic [5:0]       lsh1_q;
  logic [7:0]       exp1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      mode1_q <= 1'b0;
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      nan1_q  <= 1'b0;
      sat1_q  <= 1'b0;
      min1_q  <= 1'b0;
      tag1_q  <= '0;
      sig1_q  <= '0;
      rsh1_q  <= '0;
      mag1_q  <= '0;
      lsh1_q  <= '0;
      exp1_q  <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      mode1_q <= in_mode;
      sign1_q <= in_mode ? x_val[W-1] : in_data[31];
      zero1_q <= in_mode ? (x_val == '0) : (f_exp == '0);
      nan1_q  <= f_nan;
      sat1_q  <= f_big && !f_nan && !f_min;
      min1_q  <= f_min;
      tag1_q  <= in_tag;
      sig1_q  <= {1'b1, f_man};
      rsh1_q  <= f_rsh;
      mag1_q  <= x_mag;
      lsh1_q  <= 6'(MW - 1) - lod;
      exp1_q  <= 8'(127 - FRAC_BITS) + {2'b0, lod};
    end
  end

  // ---------------- Stage 2: barrel shift ----------------
  logic [W-1:0] fmag_d;
  logic [22:0]  mant_d;

  assign fmag_d = W'({8'b0, sig1_q, 32'b0} >> rsh1_q);
  // Leading one moves to bit MW+23; the 23 bits beneath it are the mantissa.
  assign mant_d = 23'({mag1_q, 24'b0} << lsh1_q >> MW);

  logic             v2_q, mode2_q, sign2_q, zero2_q, nan2_q, sat2_q, min2_q;
  logic [TAG_W-1:0] tag2_q;
  logic [W-1:0]     fmag2_q;
  logic [22:0]      mant2_q;
  logic [7:0]       exp2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      mode2_q <= 1'b0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      nan2_q  <= 1'b0;
      sat2_q  <= 1'b0;
      min2_q  <= 1'b0;
      tag2_q  <= '0;
      fmag2_q <= '0;
      mant2_q <= '0;
      exp2_q  <= '0;
    end else if (adv) begin
      v2_q    <= v1_q;
      mode2_q <= mode1_q;
      sign2_q <= sign1_q;
      zero2_q <= zero1_q;
      nan2_q  <= nan1_q;
      sat2_q  <= sat1_q;
      min2_q  <= min1_q;
      tag2_q  <= tag1_q;
      fmag2_q <= fmag_d;
      mant2_q <= mant_d;
      exp2_q  <= exp1_q;
    end
  end

  // ---------------- Stage 3: negate, saturate, pack ----------------
  logic [31:0] res_d;
  logic        ovf_d, nan_d;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    nan_d = 1'b0;
    if (mode2_q) begin
      if (!zero2_q) res_d = {sign2_q, exp2_q, mant2_q};
    end else if (nan2_q) begin
      res_d = sext(POS_MAX);
      nan_d = 1'b1;
    end else if (sat2_q) begin
      res_d = sext(sign2_q ? NEG_MIN : POS_MAX);
      ovf_d = 1'b1;
    end else if (min2_q) begin
      res_d = sext(NEG_MIN);
    end else if (!zero2_q) begin
      res_d = sext(sign2_q ? -fmag2_q : fmag2_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_mode  <= 1'b0;
      out_ovf   <= 1'b0;
      out_nan   <= 1'b0;
    end else if (adv) begin
      out_valid <= v2_q;
      if (v2_q) begin
        out_data <= res_d;
        out_tag  <= tag2_q;
        out_mode <= mode2_q;
        out_ovf  <= ovf_d;
        out_nan  <= nan_d;
      end
    end
  end

endmodule

// File: tb/tb_fl_fix_conv_pipe.sv
// Scoreboard bench for fl_fix_conv_pipe at the default 2.20 fixed format.
module tb_fl_fix_conv_pipe;

  localparam int INT_BITS  = 2;
  localparam int FRAC_BITS = 20;
  localparam int TAG_W     = 4;
  localparam int W         = INT_BITS + FRAC_BITS;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             mode;
    logic             ovf;
    logic             nan;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_mode;
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_mode, out_ovf, out_nan;

  int          checks = 0;
  int          failures = 0;
  int          recv = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic [31:0] last_data;
  exp_t        sb[$];

  fl_fix_conv_pipe #(
    .INT_BITS (INT_BITS),
    .FRAC_BITS(FRAC_BITS),
    .TAG_W    (TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_mode (out_mode),
    .out_ovf  (out_ovf),
    .out_nan  (out_nan)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference models ----------------
  function automatic exp_t mk(input logic [31:0] d, input logic [TAG_W-1:0] t, input logic m,
                              input logic o, input logic n);
    exp_t r;
    r.data = d; r.tag = t; r.mode = m; r.ovf = o; r.nan = n;
    return r;
  endfunction

  function automatic exp_t m_f2x(input logic [31:0] f, input logic [TAG_W-1:0] t);
    exp_t   r;
    longint sig, mag, lim, val;
    int     e, sh;
    logic   lost;
    r = mk(32'h0, t, 1'b0, 1'b0, 1'b0);
    e   = int'(f[30:23]);
    sig = longint'({1'b1, f[22:0]});
    lim = longint'(1) << (W - 1);
    val = 0;
    lost = 1'b0;
    if (e == 0) begin
      val = 0;
    end else if (e == 255 && f[22:0] != 0) begin
      val = lim - 1;
      r.nan = 1'b1;
    end else begin
      sh = e - 150 + FRAC_BITS;
      if (e == 255 || sh > 30) begin
        mag = lim; lost = 1'b1;
      end else if (sh >= 0) begin
        mag = sig << sh;
      end else if (sh <= -25) begin
        mag = 0;
      end else begin
        mag  = sig >> (-sh);
        lost = (sig & ((longint'(1) << (-sh)) - 1)) != 0;
      end
      if (mag > lim || (mag == lim && (!f[31] || lost))) begin
        r.ovf = 1'b1;
        val = f[31] ? -lim : lim - 1;
      end else begin
        val = f[31] ? -mag : mag;
      end
    end
    r.data = 32'(val);
    return r;
  endfunction

  function automatic exp_t m_x2f(input logic [W-1:0] x, input logic [TAG_W-1:0] t);
    exp_t   r;
    longint xs, mag, mant;
    int     p;
    r = mk(32'h0, t, 1'b1, 1'b0, 1'b0);
    if (x != 0) begin
      xs  = longint'(signed'(x));
      mag = (xs < 0) ? -xs : xs;
      p = 0;
      for (int i = 0; i < 40; i++) if (mag[i]) p = i;
      mant = ((mag - (longint'(1) << p)) << 23) >> p;
      r.data = {x[W-1], 8'(127 + p - FRAC_BITS), 23'(mant)};
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_float();
    logic [31:0] f;
    f = $urandom();
    case ($urandom_range(0, 9))
      0: f[30:23] = 8'd0;
      1: f[30:23] = 8'hFF;
      2: f[30:23] = 8'd128;
      3: begin f[30:23] = 8'd128; f[22:0] = '0; end
      default: f[30:23] = 8'($urandom_range(100, 129));
    endcase
    return f;
  endfunction

  // ---------------- output side ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    exp_t got, e, held;
    logic hold_chk;
    hold_chk = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = mk(out_data, out_tag, out_mode, out_ovf, out_nan);
      if (rst) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk && out_valid) begin
          checks++;
          if (got !== held) begin
            failures++;
            $display("FAIL hold_stable got=%h required=%h", got, held);
          end
        end
        hold_chk = out_valid && !out_ready;
        held = got;
        if (out_valid && out_ready) begin
          recv++;
          last_data = out_data;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output data=%h tag=%h required no output", out_data, out_tag);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              failures++;
              $display("FAIL out_compare got data=%h tag=%h mode=%b ovf=%b nan=%b required data=%h tag=%h mode=%b ovf=%b nan=%b",
                       got.data, got.tag, got.mode, got.ovf, got.nan,
                       e.data, e.tag, e.mode, e.ovf, e.nan);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic mode, input logic [31:0] data, input logic [TAG_W-1:0] tag,
                      input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1; in_mode = mode; in_data = data; in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout tag=%0d in_ready=%b required 1", tag, in_ready);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t got;
    #3;
    got = mk(out_data, out_tag, out_mode, out_ovf, out_nan);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b required 0", out_valid);
    end
    checks++;
    if (got !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h required 0", got);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency(input logic [31:0] d, input exp_t e);
    in_valid = 1'b1; in_mode = e.mode; in_data = d; in_tag = e.tag;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL latency_accept in_ready=%b required 1", in_ready);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 2)) begin
        failures++;
        $display("FAIL latency cycle=%0d out_valid=%b required %b", k + 1, out_valid, k == 2);
      end
    end
    wait_drain();
  endtask

  task automatic test_directed();
    ready_mode = 0;
    send(0, 32'h3F800000, 4'd1, mk(32'h00100000, 4'd1, 0, 0, 0));
    send(0, 32'hBFC00000, 4'd2, mk(32'hFFE80000, 4'd2, 0, 0, 0));
    send(0, 32'h40000000, 4'd3, mk(32'h001FFFFF, 4'd3, 0, 1, 0));
    send(0, 32'hC0000000, 4'd4, mk(32'hFFE00000, 4'd4, 0, 0, 0));
    send(0, 32'h7FC00000, 4'd5, mk(32'h001FFFFF, 4'd5, 0, 0, 1));
    send(0, 32'h00000001, 4'd6, mk(32'h00000000, 4'd6, 0, 0, 0));
    send(0, 32'hFF800000, 4'd7, mk(32'hFFE00000, 4'd7, 0, 1, 0));
    send(0, 32'h80000000, 4'd8, mk(32'h00000000, 4'd8, 0, 0, 0));
    send(1, 32'h00080000, 4'd9, mk(32'h3F000000, 4'd9, 1, 0, 0));
    send(1, 32'h00200000, 4'd10, mk(32'hC0000000, 4'd10, 1, 0, 0));
    send(1, 32'h00000001, 4'd11, mk(32'h35800000, 4'd11, 1, 0, 0));
    send(1, 32'hFFC00000, 4'd12, mk(32'h00000000, 4'd12, 1, 0, 0));
    send(1, 32'h003FFFFF, 4'd13, mk(32'hB5800000, 4'd13, 1, 0, 0));
    send(1, 32'h001FFFFF, 4'd14, mk(32'h3FFFFFF8, 4'd14, 1, 0, 0));
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int start;
    start = recv;
    ready_mode = 0;
    fork
      begin
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
          if (i % 2 == 1) begin
            d = $urandom();
            send(1, d, TAG_W'(i), m_x2f(d[W-1:0], TAG_W'(i)));
          end else begin
            d = rnd_float();
            send(0, d, TAG_W'(i), m_f2x(d, TAG_W'(i)));
          end
        end
      end
      begin
        repeat (4) @(posedge clk);
        ready_mode = 2;
        repeat (6) begin
          @(negedge clk);
          if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
              failures++; $display("FAIL stall_in_ready got=%b required 0", in_ready);
            end
          end
        end
        ready_mode = 0;
      end
    join
    wait_drain();
    checks++;
    if (recv - start !== 8) begin
      failures++; $display("FAIL stream_count got=%0d required 8", recv - start);
    end
  endtask

  task automatic test_reset_midflight();
    exp_t got;
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(0, 32'h3F800000, 4'd1, mk(32'h00100000, 4'd1, 0, 0, 0));
    send(1, 32'h00080000, 4'd2, mk(32'h3F000000, 4'd2, 1, 0, 0));
    send(0, 32'h40000000, 4'd3, mk(32'h001FFFFF, 4'd3, 0, 1, 0));
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midflight_full out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    sb.delete();
    #1;
    got = mk(out_data, out_tag, out_mode, out_ovf, out_nan);
    checks++;
    if (out_valid !== 1'b0 || got !== '0) begin
      failures++;
      $display("FAIL midflight_reset out_valid=%b outputs=%h required 0 0", out_valid, got);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL stale_output cycle=%0d out_valid=%b required 0", k, out_valid);
      end
    end
    @(posedge clk);
    #1;
    test_latency(32'hBFC00000, mk(32'hFFE80000, 4'd5, 0, 0, 0));
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    ready_mode = 1;
    for (int i = 0; i < 80; i++) begin
      t = TAG_W'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        send(1, d, t, m_x2f(d[W-1:0], t));
      end else begin
        d = rnd_float();
        send(0, d, t, m_f2x(d, t));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    ready_mode = 0;
  endtask

  task automatic test_round_trip();
    logic [31:0] d;
    logic [W-1:0] x;
    logic [TAG_W-1:0] t;
    ready_mode = 0;
    for (int i = 0; i < 30; i++) begin
      x = W'($urandom());
      if (i == 0) x = {1'b1, {(W-1){1'b0}}};
      if (i == 1) x = {{(W-1){1'b0}}, 1'b1};
      if (i == 2) x = {1'b0, {(W-1){1'b1}}};
      t = TAG_W'(i);
      d = $urandom();
      d[W-1:0] = x;
      send(1, d, t, m_x2f(x, t));
      wait_drain();
      send(0, last_data, t, mk(32'(signed'(x)), t, 0, 0, 0));
      wait_drain();
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_mode = 1'b0;
    in_data = '0;
    in_tag = '0;
    out_ready = 1'b1;
    last_data = '0;
    test_reset();
    test_latency(32'h3F800000, mk(32'h00100000, 4'd0, 0, 0, 0));
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    test_round_trip();
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
